// File: rtl/bsk_entry_ptr_ctrl_pkg.sv
// BSK entry pointer interface: shared constants, pointer/error types and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bsk_entry_ptr_ctrl_pkg;

    localparam int BSK_SLOT_NB        = 8;
    localparam int BSK_SLOT_PER_BATCH = 4;
    localparam int BSK_BATCH_NB       = 2;
    localparam int BSK_PTR_W          = $clog2(BSK_SLOT_NB) + 1;

    // Ring pointer; MSB is the wrap bit so full and empty are distinguishable.
    typedef logic [BSK_PTR_W-1:0] bsk_ptr_t;

    // Two-bit error vector, merged into the parent's wider error word.
    typedef struct packed {
        logic udf;  // [1] release requested with nothing consumable
        logic ovf;  // [0] fill signalled while the ring is full
    } bsk_error_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } bsk_state_t;

endpackage

// File: rtl/bsk_ring_ptr.sv
// BSK ring pointer pair: occupancy, full/empty and overflow/underflow detection.
// Latency: pointers move one cycle after an accepted event; pulses are registered (1 cycle).
// Backpressure: none; unacceptable events are dropped and flagged on error.
module bsk_ring_ptr
    import bsk_entry_ptr_ctrl_pkg::*;
#(
    parameter int SLOT_NB = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_inc,
    input  logic                       rd_req,
    input  logic                       rd_allow,
    output logic                       rd_acc,
    output logic                       rel_pulse,
    output logic [$clog2(SLOT_NB)-1:0] rd_idx,
    output logic [$clog2(SLOT_NB):0]   occupancy,
    output logic [1:0]                 error
);

    localparam int IW = $clog2(SLOT_NB);
    localparam int PW = IW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          wr_acc;
    bsk_error_t    err_nxt;
    bsk_error_t    err_q;

    // Modulo-2*SLOT_NB difference falls out of the natural PW-bit wrap.
    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == PW'(SLOT_NB));
    assign empty     = (occupancy == '0);
    assign rd_idx    = rd_ptr[IW-1:0];

    // A release in the same cycle frees a slot, so a fill at full still fits.
    assign rd_acc        = rd_req & rd_allow & ~empty;
    assign wr_acc        = wr_inc & (~full | rd_acc);
    assign err_nxt.ovf   = wr_inc & ~wr_acc;
    assign err_nxt.udf   = rd_req & ~rd_acc;
    assign error         = err_q;

    // Pointer advance on accepted fill / release events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // One-cycle registered release and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_pulse <= 1'b0;
            err_q     <= '0;
        end else begin
            rel_pulse <= rd_acc;
            err_q     <= err_nxt;
        end
    end

endmodule

// File: rtl/bsk_entry_ptr_ctrl.sv
// Consumer-side BSK entry pointer controller: batch command FSM over the BSK slot ring.
// Latency: batch announce, release and error pulses appear the cycle after their event.
// Backpressure: cmd_rdy is low while a batch runs; slot events are never stalled, only dropped.
module bsk_entry_ptr_ctrl
    import bsk_entry_ptr_ctrl_pkg::*;
#(
    parameter int SLOT_NB        = BSK_SLOT_NB,
    parameter int BATCH_NB       = BSK_BATCH_NB,
    parameter int SLOT_PER_BATCH = BSK_SLOT_PER_BATCH
) (
    input  logic                        prc_clk,
    input  logic                        prc_rst,
    input  logic [$clog2(BATCH_NB)-1:0] cmd_batch_id,
    input  logic                        cmd_vld,
    output logic                        cmd_rdy,
    input  logic                        inc_wr_ptr,
    input  logic                        slot_done,
    output logic [BATCH_NB-1:0]         batch_start_1h,
    output logic                        inc_rd_ptr,
    output logic                        slot_avail,
    output logic [$clog2(SLOT_NB)-1:0]  slot_idx,
    output logic [$clog2(SLOT_NB):0]    occupancy,
    output logic [1:0]                  error
);

    localparam int DW = $clog2(SLOT_PER_BATCH + 1);

    bsk_state_t    state;
    logic [DW-1:0] done_cnt;
    logic          rd_acc;

    bsk_ring_ptr #(
        .SLOT_NB (SLOT_NB)
    ) u_ring (
        .clk       (prc_clk),
        .rst       (prc_rst),
        .wr_inc    (inc_wr_ptr),
        .rd_req    (slot_done),
        .rd_allow  (state == ST_RUN),
        .rd_acc    (rd_acc),
        .rel_pulse (inc_rd_ptr),
        .rd_idx    (slot_idx),
        .occupancy (occupancy),
        .error     (error)
    );

    assign slot_avail = (state == ST_RUN) && (occupancy != '0);

    // Batch FSM; the accepted batch id lives on only as the registered one-hot announce.
    always_ff @(posedge prc_clk or posedge prc_rst) begin
        if (prc_rst) begin
            state          <= ST_IDLE;
            cmd_rdy        <= 1'b1;
            done_cnt       <= '0;
            batch_start_1h <= '0;
        end else begin
            batch_start_1h <= '0;
            case (state)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        state          <= ST_RUN;
                        cmd_rdy        <= 1'b0;
                        done_cnt       <= '0;
                        batch_start_1h <= BATCH_NB'(1) << cmd_batch_id;
                    end
                end
                ST_RUN: begin
                    if (rd_acc) begin
                        if (done_cnt == DW'(SLOT_PER_BATCH - 1)) begin
                            state    <= ST_IDLE;
                            cmd_rdy  <= 1'b1;
                            done_cnt <= '0;
                        end else begin
                            done_cnt <= done_cnt + DW'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cmd_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsk_entry_ptr_ctrl.sv
module tb_bsk_entry_ptr_ctrl;

    logic       prc_clk = 1'b0;
    logic       prc_rst;
    logic [0:0] cmd_batch_id;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic       inc_wr_ptr;
    logic       slot_done;
    logic [1:0] batch_start_1h;
    logic       inc_rd_ptr;
    logic       slot_avail;
    logic [2:0] slot_idx;
    logic [3:0] occupancy;
    logic [1:0] error;

    int total = 0;
    int bad   = 0;

    bsk_entry_ptr_ctrl #(
        .SLOT_NB        (8),
        .BATCH_NB       (2),
        .SLOT_PER_BATCH (4)
    ) dut (
        .prc_clk        (prc_clk),
        .prc_rst        (prc_rst),
        .cmd_batch_id   (cmd_batch_id),
        .cmd_vld        (cmd_vld),
        .cmd_rdy        (cmd_rdy),
        .inc_wr_ptr     (inc_wr_ptr),
        .slot_done      (slot_done),
        .batch_start_1h (batch_start_1h),
        .inc_rd_ptr     (inc_rd_ptr),
        .slot_avail     (slot_avail),
        .slot_idx       (slot_idx),
        .occupancy      (occupancy),
        .error          (error)
    );

    always #5 prc_clk = ~prc_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge prc_clk);
        #1;
    endtask

    // {cmd_rdy, batch_start_1h, inc_rd_ptr, slot_avail, slot_idx, occupancy, error}
    task automatic test_reset();
        prc_rst = 1'b1; cmd_vld = 1'b0; cmd_batch_id = 1'b0;
        inc_wr_ptr = 1'b0; slot_done = 1'b0;
        step(); step();
        total++;
        if ({cmd_rdy, batch_start_1h, inc_rd_ptr, slot_avail, slot_idx, occupancy, error}
            !== {1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 4'd0, 2'b00}) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b",
                {cmd_rdy, batch_start_1h, inc_rd_ptr, slot_avail, slot_idx, occupancy, error},
                {1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 4'd0, 2'b00});
        end
        prc_rst = 1'b0;
        step();
        total++;
        if (cmd_rdy !== 1'b1 || occupancy !== 4'd0) begin
            bad++;
            $display("FAIL reset_release cmd_rdy=%b occ=%0d want 1/0", cmd_rdy, occupancy);
        end
    endtask

    task automatic test_batch_start();
        inc_wr_ptr = 1'b1;
        repeat (4) step();
        inc_wr_ptr = 1'b0;
        total++;
        if (occupancy !== 4'd4 || slot_avail !== 1'b0 || cmd_rdy !== 1'b1) begin
            bad++;
            $display("FAIL fill_idle occ=%0d avail=%b rdy=%b want 4/0/1", occupancy, slot_avail, cmd_rdy);
        end
        cmd_batch_id = 1'b1; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        total++;
        if (batch_start_1h !== 2'b10 || cmd_rdy !== 1'b0 || slot_avail !== 1'b1) begin
            bad++;
            $display("FAIL batch_start bs=%b rdy=%b avail=%b want 10/0/1", batch_start_1h, cmd_rdy, slot_avail);
        end
        step();
        total++;
        if (batch_start_1h !== 2'b00) begin
            bad++;
            $display("FAIL batch_start_pulse_width bs=%b want 00", batch_start_1h);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (slot_idx !== 3'(i)) begin
                bad++;
                $display("FAIL b2b_slot_idx[%0d] got=%0d want=%0d", i, slot_idx, i);
            end
            slot_done = 1'b1;
            step();
            total++;
            if (inc_rd_ptr !== 1'b1 || occupancy !== 4'(3 - i) || cmd_rdy !== (i == 3)) begin
                bad++;
                $display("FAIL b2b_release[%0d] inc_rd=%b occ=%0d rdy=%b want 1/%0d/%0b",
                         i, inc_rd_ptr, occupancy, cmd_rdy, 3 - i, (i == 3));
            end
        end
        slot_done = 1'b0;
        step();
        total++;
        if (inc_rd_ptr !== 1'b0 || slot_avail !== 1'b0 || error !== 2'b00) begin
            bad++;
            $display("FAIL b2b_after inc_rd=%b avail=%b err=%b want 0/0/00", inc_rd_ptr, slot_avail, error);
        end
    endtask

    task automatic test_overflow();
        inc_wr_ptr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if (error !== ((i == 8) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("FAIL overflow_err[%0d] got=%b want=%b", i, error, (i == 8) ? 2'b01 : 2'b00);
            end
        end
        inc_wr_ptr = 1'b0;
        step();
        total++;
        if (occupancy !== 4'd8 || error !== 2'b00) begin
            bad++;
            $display("FAIL overflow_final occ=%0d err=%b want 8/00", occupancy, error);
        end
    endtask

    task automatic test_full_simul();
        cmd_batch_id = 1'b0; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        total++;
        if (batch_start_1h !== 2'b01 || slot_avail !== 1'b1 || slot_idx !== 3'd4) begin
            bad++;
            $display("FAIL full_cmd bs=%b avail=%b idx=%0d want 01/1/4", batch_start_1h, slot_avail, slot_idx);
        end
        inc_wr_ptr = 1'b1; slot_done = 1'b1;
        step();
        inc_wr_ptr = 1'b0;
        total++;
        if (occupancy !== 4'd8 || error !== 2'b00 || inc_rd_ptr !== 1'b1 || slot_idx !== 3'd5) begin
            bad++;
            $display("FAIL full_simul occ=%0d err=%b inc_rd=%b idx=%0d want 8/00/1/5",
                     occupancy, error, inc_rd_ptr, slot_idx);
        end
        repeat (3) step();
        slot_done = 1'b0;
        total++;
        if (occupancy !== 4'd5 || cmd_rdy !== 1'b1 || slot_idx !== 3'd0) begin
            bad++;
            $display("FAIL full_finish occ=%0d rdy=%b idx=%0d want 5/1/0", occupancy, cmd_rdy, slot_idx);
        end
    endtask

    task automatic test_underflow();
        slot_done = 1'b1;
        step();
        slot_done = 1'b0;
        total++;
        if (error !== 2'b10 || inc_rd_ptr !== 1'b0 || occupancy !== 4'd5 || slot_idx !== 3'd0) begin
            bad++;
            $display("FAIL udf_idle err=%b inc_rd=%b occ=%0d idx=%0d want 10/0/5/0",
                     error, inc_rd_ptr, occupancy, slot_idx);
        end
        cmd_batch_id = 1'b1; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        slot_done = 1'b1;
        repeat (4) step();
        slot_done = 1'b0;
        total++;
        if (occupancy !== 4'd1 || cmd_rdy !== 1'b1 || slot_idx !== 3'd4) begin
            bad++;
            $display("FAIL udf_batch occ=%0d rdy=%b idx=%0d want 1/1/4", occupancy, cmd_rdy, slot_idx);
        end
        cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        slot_done = 1'b1;
        step();
        slot_done = 1'b0;
        total++;
        if (occupancy !== 4'd0 || slot_avail !== 1'b0 || cmd_rdy !== 1'b0) begin
            bad++;
            $display("FAIL udf_drained occ=%0d avail=%b rdy=%b want 0/0/0", occupancy, slot_avail, cmd_rdy);
        end
        slot_done = 1'b1;
        step();
        slot_done = 1'b0;
        total++;
        if (error !== 2'b10 || inc_rd_ptr !== 1'b0 || occupancy !== 4'd0 || slot_idx !== 3'd5) begin
            bad++;
            $display("FAIL udf_empty err=%b inc_rd=%b occ=%0d idx=%0d want 10/0/0/5",
                     error, inc_rd_ptr, occupancy, slot_idx);
        end
        inc_wr_ptr = 1'b1;
        repeat (3) step();
        inc_wr_ptr = 1'b0;
        slot_done = 1'b1;
        repeat (3) step();
        slot_done = 1'b0;
        total++;
        if (cmd_rdy !== 1'b1 || occupancy !== 4'd0 || slot_idx !== 3'd0) begin
            bad++;
            $display("FAIL udf_recover rdy=%b occ=%0d idx=%0d want 1/0/0", cmd_rdy, occupancy, slot_idx);
        end
    endtask

    task automatic test_wrap();
        int exp_rd = 0;
        for (int b = 0; b < 3; b++) begin
            inc_wr_ptr = 1'b1;
            repeat (4) step();
            inc_wr_ptr = 1'b0;
            cmd_batch_id = 1'(b % 2); cmd_vld = 1'b1;
            step();
            cmd_vld = 1'b0;
            total++;
            if (batch_start_1h !== ((b % 2 == 1) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL wrap_bs[%0d] got=%b", b, batch_start_1h);
            end
            for (int j = 0; j < 4; j++) begin
                total++;
                if (slot_idx !== 3'(exp_rd % 8) || occupancy !== 4'(4 - j)) begin
                    bad++;
                    $display("FAIL wrap_idx[%0d.%0d] idx=%0d occ=%0d want %0d/%0d",
                             b, j, slot_idx, occupancy, exp_rd % 8, 4 - j);
                end
                slot_done = 1'b1;
                step();
                slot_done = 1'b0;
                exp_rd++;
                total++;
                if (inc_rd_ptr !== 1'b1 || error !== 2'b00) begin
                    bad++;
                    $display("FAIL wrap_rel[%0d.%0d] inc_rd=%b err=%b want 1/00", b, j, inc_rd_ptr, error);
                end
            end
            total++;
            if (cmd_rdy !== 1'b1 || occupancy !== 4'd0) begin
                bad++;
                $display("FAIL wrap_end[%0d] rdy=%b occ=%0d want 1/0", b, cmd_rdy, occupancy);
            end
        end
    endtask

    task automatic test_reset_mid();
        inc_wr_ptr = 1'b1;
        repeat (4) step();
        inc_wr_ptr = 1'b0;
        cmd_batch_id = 1'b0; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        slot_done = 1'b1;
        step();
        slot_done = 1'b0;
        total++;
        if (inc_rd_ptr !== 1'b1 || slot_idx !== 3'd5 || occupancy !== 4'd3) begin
            bad++;
            $display("FAIL mid_pre inc_rd=%b idx=%0d occ=%0d want 1/5/3", inc_rd_ptr, slot_idx, occupancy);
        end
        #2;
        prc_rst = 1'b1;
        #1;
        total++;
        if ({cmd_rdy, batch_start_1h, inc_rd_ptr, slot_avail, slot_idx, occupancy, error}
            !== {1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 4'd0, 2'b00}) begin
            bad++;
            $display("FAIL mid_async_reset got=%b want=%b",
                {cmd_rdy, batch_start_1h, inc_rd_ptr, slot_avail, slot_idx, occupancy, error},
                {1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 4'd0, 2'b00});
        end
        step();
        prc_rst = 1'b0;
        step();
        total++;
        if (inc_rd_ptr !== 1'b0 || occupancy !== 4'd0 || cmd_rdy !== 1'b1 || slot_avail !== 1'b0) begin
            bad++;
            $display("FAIL mid_after inc_rd=%b occ=%0d rdy=%b avail=%b want 0/0/1/0",
                     inc_rd_ptr, occupancy, cmd_rdy, slot_avail);
        end
    endtask

    initial begin
        test_reset();
        test_batch_start();
        test_back_to_back();
        test_overflow();
        test_full_simul();
        test_underflow();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
